// File: rtl/snake_pkg.sv
// Shared snake-game constants: grid defaults, coordinate widths,
// apple placer state encoding and playfield cell count.
package snake_pkg;

    localparam int X_W = 8;
    localparam int Y_W = 7;

    localparam int GRID_W_DEF = 40;
    localparam int GRID_H_DEF = 30;

    function automatic int cell_count(input int w, input int h);
        return w * h;
    endfunction

    localparam int CELLS_DEF = cell_count(GRID_W_DEF, GRID_H_DEF);

    localparam int ST_W = 4;

    localparam logic [ST_W-1:0] ST_IDLE   = 4'd0;
    localparam logic [ST_W-1:0] ST_TICK   = 4'd1;
    localparam logic [ST_W-1:0] ST_SAMPLE = 4'd2;
    localparam logic [ST_W-1:0] ST_REDUCE = 4'd3;
    localparam logic [ST_W-1:0] ST_QUERY  = 4'd4;
    localparam logic [ST_W-1:0] ST_CHECK  = 4'd5;
    localparam logic [ST_W-1:0] ST_SCAN_Q = 4'd6;
    localparam logic [ST_W-1:0] ST_SCAN_C = 4'd7;
    localparam logic [ST_W-1:0] ST_DONE   = 4'd8;
    localparam logic [ST_W-1:0] ST_FULL   = 4'd9;

endpackage

// File: rtl/apple_coord_wrap.sv
// Scan cursor step: next cell in raster order, wrapping x then y.
// Ports: x/y current cursor in, nx/ny next cursor out.
module apple_coord_wrap
    import snake_pkg::*;
#(
    parameter int GRID_W = GRID_W_DEF,
    parameter int GRID_H = GRID_H_DEF
) (
    input  logic [X_W-1:0] x,
    input  logic [Y_W-1:0] y,
    output logic [X_W-1:0] nx,
    output logic [Y_W-1:0] ny
);

    localparam logic [X_W-1:0] X_LAST = X_W'(GRID_W - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(GRID_H - 1);

    always_comb begin
        nx = x + 1'b1;
        ny = y;
        if (x == X_LAST) begin
            nx = '0;
            ny = (y == Y_LAST) ? '0 : y + 1'b1;
        end
    end

endmodule

// File: rtl/apple_placer.sv
// Apple placer: pulls a random coordinate, folds it into the grid,
// retries on occupied cells, then falls back to a linear scan.
// Ports: clk/rst_n; req in, busy/done/full status out;
// apple_valid/apple_x/apple_y result; gen_tick/gen_ax/gen_ay generator;
// occ_rd_en/occ_x/occ_y/occ_hit occupancy RAM (1-cycle read).
module apple_placer
    import snake_pkg::*;
#(
    parameter int GRID_W    = GRID_W_DEF,
    parameter int GRID_H    = GRID_H_DEF,
    parameter int MAX_TRIES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req,
    output logic           busy,
    output logic           done,
    output logic           full,
    output logic           apple_valid,
    output logic [X_W-1:0] apple_x,
    output logic [Y_W-1:0] apple_y,
    output logic           gen_tick,
    input  logic [X_W-1:0] gen_ax,
    input  logic [Y_W-1:0] gen_ay,
    output logic           occ_rd_en,
    output logic [X_W-1:0] occ_x,
    output logic [Y_W-1:0] occ_y,
    input  logic           occ_hit
);

    localparam int CELLS = cell_count(GRID_W, GRID_H);
    localparam int SW    = $clog2(CELLS + 1);
    localparam int TW    = $clog2(MAX_TRIES + 1);

    localparam logic [X_W-1:0] GW = X_W'(GRID_W);
    localparam logic [Y_W-1:0] GH = Y_W'(GRID_H);

    logic [ST_W-1:0] state;
    logic [TW-1:0]   try_cnt;
    logic [SW-1:0]   scan_cnt;
    logic [X_W-1:0]  cx;
    logic [Y_W-1:0]  cy;
    logic [X_W-1:0]  ux;
    logic [Y_W-1:0]  uy;
    logic [X_W-1:0]  wx;
    logic [Y_W-1:0]  wy;
    logic            x_ok;
    logic            y_ok;

    apple_coord_wrap #(
        .GRID_W(GRID_W),
        .GRID_H(GRID_H)
    ) u_wrap (
        .x (ux),
        .y (uy),
        .nx(wx),
        .ny(wy)
    );

    assign x_ok = cx < GW;
    assign y_ok = cy < GH;

    assign busy      = state != ST_IDLE;
    assign done      = state == ST_DONE;
    assign full      = state == ST_FULL;
    assign gen_tick  = state == ST_TICK;
    assign occ_rd_en = (state == ST_QUERY) || (state == ST_SCAN_Q);
    assign occ_x     = (state == ST_SCAN_Q) ? ux : cx;
    assign occ_y     = (state == ST_SCAN_Q) ? uy : cy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            try_cnt     <= '0;
            scan_cnt    <= '0;
            cx          <= '0;
            cy          <= '0;
            ux          <= '0;
            uy          <= '0;
            apple_x     <= '0;
            apple_y     <= '0;
            apple_valid <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (req) begin
                        apple_valid <= 1'b0;
                        try_cnt     <= '0;
                        state       <= ST_TICK;
                    end
                end
                ST_TICK: state <= ST_SAMPLE;
                ST_SAMPLE: begin
                    cx    <= gen_ax;
                    cy    <= gen_ay;
                    state <= ST_REDUCE;
                end
                // Repeated subtraction; both axes fold in parallel.
                ST_REDUCE: begin
                    if (x_ok && y_ok) begin
                        state <= ST_QUERY;
                    end else begin
                        if (!x_ok) cx <= cx - GW;
                        if (!y_ok) cy <= cy - GH;
                    end
                end
                ST_QUERY: state <= ST_CHECK;
                ST_CHECK: begin
                    if (!occ_hit) begin
                        apple_x     <= cx;
                        apple_y     <= cy;
                        apple_valid <= 1'b1;
                        state       <= ST_DONE;
                    end else if (try_cnt + 1'b1 < TW'(MAX_TRIES)) begin
                        try_cnt <= try_cnt + 1'b1;
                        state   <= ST_TICK;
                    end else begin
                        ux       <= cx;
                        uy       <= cy;
                        scan_cnt <= '0;
                        state    <= ST_SCAN_Q;
                    end
                end
                ST_SCAN_Q: state <= ST_SCAN_C;
                ST_SCAN_C: begin
                    if (!occ_hit) begin
                        apple_x     <= ux;
                        apple_y     <= uy;
                        apple_valid <= 1'b1;
                        state       <= ST_DONE;
                    end else if (scan_cnt == SW'(CELLS - 1)) begin
                        state <= ST_FULL;
                    end else begin
                        ux       <= wx;
                        uy       <= wy;
                        scan_cnt <= scan_cnt + 1'b1;
                        state    <= ST_SCAN_Q;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_FULL: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_apple_placer.sv
// Directed bench for apple_placer with generator and occupancy models.
// Ports: none (top-level bench).
module tb_apple_placer;

    logic       clk;
    logic       rst_n;
    logic       req;
    logic       busy;
    logic       done;
    logic       full;
    logic       apple_valid;
    logic [7:0] apple_x;
    logic [6:0] apple_y;
    logic       gen_tick;
    logic [7:0] gen_ax;
    logic [6:0] gen_ay;
    logic       occ_rd_en;
    logic [7:0] occ_x;
    logic [6:0] occ_y;
    logic       occ_hit;

    int checks = 0;
    int errors = 0;

    logic [7:0] tab_x [8];
    logic [6:0] tab_y [8];
    int ticks = 0;
    int reads = 0;
    int dones = 0;
    int fulls = 0;
    int both  = 0;
    logic [7:0] rx;
    logic [6:0] ry;
    int occ_mode;
    logic [7:0] fx;
    logic [6:0] fy;

    apple_placer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .busy       (busy),
        .done       (done),
        .full       (full),
        .apple_valid(apple_valid),
        .apple_x    (apple_x),
        .apple_y    (apple_y),
        .gen_tick   (gen_tick),
        .gen_ax     (gen_ax),
        .gen_ay     (gen_ay),
        .occ_rd_en  (occ_rd_en),
        .occ_x      (occ_x),
        .occ_y      (occ_y),
        .occ_hit    (occ_hit)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // generator: value appears the cycle after the tick
    always @(posedge clk) begin
        if (gen_tick) begin
            gen_ax <= tab_x[ticks % 8];
            gen_ay <= tab_y[ticks % 8];
            ticks  <= ticks + 1;
        end
    end

    // occupancy RAM: 0 all free, 1 all occupied, 2 only (fx,fy) free
    always @(posedge clk) begin
        occ_hit <= 1'b0;
        if (occ_rd_en) begin
            reads   <= reads + 1;
            rx      <= occ_x;
            ry      <= occ_y;
            occ_hit <= (occ_mode == 1) ||
                       (occ_mode == 2 && !(occ_x == fx && occ_y == fy));
        end
        if (done) dones <= dones + 1;
        if (full) fulls <= fulls + 1;
        if (done && full) both <= both + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_gen(input logic [7:0] gx, input logic [6:0] gy);
        for (int i = 0; i < 8; i++) begin
            tab_x[i] = gx;
            tab_y[i] = gy;
        end
    endtask

    // pulse req, wait for done/full, return cycles from accept edge
    task automatic run(output int n);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        chk("accept_busy", busy, 1);
        chk("accept_valid_drop", apple_valid, 0);
        n = 0;
        while (!done && !full && n < 5000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("end_seen", done | full, 1);
        @(posedge clk);
        #1;
        chk("pulse_1cyc", done | full, 0);
        chk("idle_busy", busy, 0);
    endtask

    int n, t0, r0, d0, f0, base;

    initial begin
        rst_n    = 1'b1;
        req      = 1'b0;
        occ_mode = 0;
        fx       = 8'd0;
        fy       = 7'd0;
        set_gen(8'h05, 7'h03);
        #1 rst_n = 1'b0;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", apple_valid, 0);
        chk("rst_apple", {apple_x, apple_y}, 0);
        chk("rst_strobes", {gen_tick, occ_rd_en, done, full}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // reset asserted while folding (255,127)
        set_gen(8'hFF, 7'h7F);
        @(negedge clk);
        req = 1'b1;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("pre_rst_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("async_busy", busy, 0);
        chk("async_strobes", {gen_tick, occ_rd_en, done, full}, 0);
        chk("async_occ_xy", {occ_x, occ_y}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // free cell, no reduction
        set_gen(8'h05, 7'h03);
        t0 = ticks; r0 = reads;
        run(n);
        chk("t2_latency", n, 5);
        chk("t2_ticks", ticks - t0, 1);
        chk("t2_reads", reads - r0, 1);
        chk("t2_rd_xy", {rx, ry}, {8'd5, 7'd3});
        chk("t2_apple", {apple_x, apple_y}, {8'd5, 7'd3});
        chk("t2_valid", apple_valid, 1);

        // max raw value: 6 fold cycles
        set_gen(8'hFF, 7'h7F);
        run(n);
        chk("t3_latency", n, 11);
        chk("t3_rd_xy", {rx, ry}, {8'd15, 7'd7});
        chk("t3_apple", {apple_x, apple_y}, {8'd15, 7'd7});

        // 8 occupied candidates, scan from (38,10) wraps to (1,11)
        occ_mode = 2;
        fx = 8'd1;
        fy = 7'd11;
        base = ticks;
        for (int k = 0; k < 7; k++) begin
            tab_x[(base + k) % 8] = 8'(10 + k);
            tab_y[(base + k) % 8] = 7'd20;
        end
        tab_x[(base + 7) % 8] = 8'd38;
        tab_y[(base + 7) % 8] = 7'd10;
        t0 = ticks; r0 = reads;
        run(n);
        chk("t4_ticks", ticks - t0, 8);
        chk("t4_reads", reads - r0, 12);
        chk("t4_rd_xy", {rx, ry}, {8'd1, 7'd11});
        chk("t4_apple", {apple_x, apple_y}, {8'd1, 7'd11});
        chk("t4_valid", apple_valid, 1);

        // board full
        occ_mode = 1;
        set_gen(8'h05, 7'h03);
        t0 = ticks; r0 = reads; d0 = dones; f0 = fulls;
        run(n);
        chk("t5_ticks", ticks - t0, 8);
        chk("t5_reads", reads - r0, 1208);
        chk("t5_fulls", fulls - f0, 1);
        chk("t5_dones", dones - d0, 0);
        chk("t5_valid", apple_valid, 0);
        chk("t5_apple_kept", {apple_x, apple_y}, {8'd1, 7'd11});

        // req held while busy, then back-to-back
        occ_mode = 0;
        set_gen(8'h05, 7'h03);
        t0 = ticks; d0 = dones;
        @(negedge clk);
        req = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        req = 1'b0;
        n = 0;
        while (!done && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("t6_done", done, 1);
        @(posedge clk);
        #1;
        chk("t6_ticks", ticks - t0, 1);
        chk("t6_dones", dones - d0, 1);
        chk("t6_apple", {apple_x, apple_y}, {8'd5, 7'd3});
        set_gen(8'h07, 7'h02);
        run(n);
        chk("t6b_latency", n, 5);
        chk("t6b_apple", {apple_x, apple_y}, {8'd7, 7'd2});
        chk("t6b_valid", apple_valid, 1);
        chk("never_both", both, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
